// File: rtl/regfile_pkg.sv
// Shared defaults, types and address-validity helper for the multi-port register file.
package regfile_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_DEPTH  = 32;
    localparam int unsigned RF_ADDR_W = 5;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_word_t;

    // An address names real storage only if it is in range and is not the hardwired zero register.
    function automatic logic rf_addr_valid(
        input logic [31:0] addr,
        input int unsigned depth,
        input logic        zero_reg
    );
        return (addr < depth) && !(zero_reg && (addr == 32'd0));
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One synchronous read port: address decode, write-first bypass over W0/W1, data/busy registers
// that hold while the port is not enabled.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] regs [DEPTH],
    input  logic [DEPTH-1:0]  busy_nxt,
    input  logic              w0_ok,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_ok,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    logic              addr_ok;
    logic [DATA_W-1:0] stored;
    logic              stored_busy;
    logic [DATA_W-1:0] rd_val;
    logic              rd_busy;

    assign addr_ok = rf_addr_valid(32'(addr), DEPTH, ZERO_REG);

    always_comb begin
        stored      = '0;
        stored_busy = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i)) begin
                stored      = regs[i];
                stored_busy = busy_nxt[i];
            end
        end
    end

    // W1 is checked first so a same-address collision returns the load-unit data.
    always_comb begin
        rd_val = stored;
        if (!addr_ok)
            rd_val = '0;
        else if (w1_ok && (w1_addr == addr))
            rd_val = w1_data;
        else if (w0_ok && (w0_addr == addr))
            rd_val = w0_data;
        rd_busy = addr_ok && stored_busy;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
            busy <= 1'b0;
        end else if (en) begin
            data <= rd_val;
            busy <= rd_busy;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, dual write commit (W1 priority), busy scoreboard and
// NUM_RD bypassing read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        w0_addr,
    input  logic [DATA_W-1:0]        w0_data,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        w1_addr,
    input  logic [DATA_W-1:0]        w1_data,
    input  logic [NUM_RD-1:0]        r_en,
    input  logic [NUM_RD*ADDR_W-1:0] r_addr,
    output logic [NUM_RD*DATA_W-1:0] r_data,
    output logic [NUM_RD-1:0]        r_busy,
    input  logic                     bs_en,
    input  logic [ADDR_W-1:0]        bs_addr,
    output logic                     busy_any
);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              w0_ok;
    logic              w1_ok;
    logic              bs_ok;

    assign w0_ok = we0   && rf_addr_valid(32'(w0_addr), DEPTH, ZERO_REG);
    assign w1_ok = we1   && rf_addr_valid(32'(w1_addr), DEPTH, ZERO_REG);
    assign bs_ok = bs_en && rf_addr_valid(32'(bs_addr), DEPTH, ZERO_REG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w1_ok && (w1_addr == ADDR_W'(i)))
                    regs[i] <= w1_data;
                else if (w0_ok && (w0_addr == ADDR_W'(i)))
                    regs[i] <= w0_data;
            end
        end
    end

    // Set is applied after clear: a newly issued producer outranks the retiring one.
    always_comb begin
        busy_nxt = busy;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((w0_ok && (w0_addr == ADDR_W'(i))) || (w1_ok && (w1_addr == ADDR_W'(i))))
                busy_nxt[i] = 1'b0;
            if (bs_ok && (bs_addr == ADDR_W'(i)))
                busy_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= '0;
            busy_any <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_any <= |busy_nxt;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        regfile_rd_port #(
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_rd (
            .clk     (clk),
            .reset   (reset),
            .en      (r_en[g]),
            .addr    (r_addr[g*ADDR_W +: ADDR_W]),
            .regs    (regs),
            .busy_nxt(busy_nxt),
            .w0_ok   (w0_ok),
            .w0_addr (w0_addr),
            .w0_data (w0_data),
            .w1_ok   (w1_ok),
            .w1_addr (w1_addr),
            .w1_data (w1_data),
            .data    (r_data[g*DATA_W +: DATA_W]),
            .busy    (r_busy[g])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with an array-level reference model checked every cycle
// and literal expectations for the key scenarios.
module tb_regfile_mp;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 24;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NUM_RD = 3;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     we0 = 1'b0;
    logic [ADDR_W-1:0]        w0_addr = '0;
    logic [DATA_W-1:0]        w0_data = '0;
    logic                     we1 = 1'b0;
    logic [ADDR_W-1:0]        w1_addr = '0;
    logic [DATA_W-1:0]        w1_data = '0;
    logic [NUM_RD-1:0]        r_en = '0;
    logic [NUM_RD*ADDR_W-1:0] r_addr = '0;
    logic [NUM_RD*DATA_W-1:0] r_data;
    logic [NUM_RD-1:0]        r_busy;
    logic                     bs_en = 1'b0;
    logic [ADDR_W-1:0]        bs_addr = '0;
    logic                     busy_any;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    regfile_mp #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_REG(1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .we0     (we0),
        .w0_addr (w0_addr),
        .w0_data (w0_data),
        .we1     (we1),
        .w1_addr (w1_addr),
        .w1_data (w1_data),
        .r_en    (r_en),
        .r_addr  (r_addr),
        .r_data  (r_data),
        .r_busy  (r_busy),
        .bs_en   (bs_en),
        .bs_addr (bs_addr),
        .busy_any(busy_any)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural register/busy arrays updated in program order.
    logic [DATA_W-1:0] m_regs [DEPTH];
    bit                m_busy [DEPTH];
    logic [DATA_W-1:0] exp_data [NUM_RD];
    bit                exp_busy [NUM_RD];
    bit                exp_any;

    function automatic bit real_reg(input int a);
        return (a > 0) && (a < int'(DEPTH));
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            for (int p = 0; p < int'(NUM_RD); p++) begin
                exp_data[p] = '0;
                exp_busy[p] = 1'b0;
            end
            exp_any = 1'b0;
        end else begin
            if (we0 && real_reg(int'(w0_addr))) begin
                m_regs[w0_addr] = w0_data;
                m_busy[w0_addr] = 1'b0;
            end
            if (we1 && real_reg(int'(w1_addr))) begin
                m_regs[w1_addr] = w1_data;
                m_busy[w1_addr] = 1'b0;
            end
            if (bs_en && real_reg(int'(bs_addr)))
                m_busy[bs_addr] = 1'b1;
            for (int p = 0; p < int'(NUM_RD); p++) begin
                int a;
                a = int'(r_addr[p*ADDR_W +: ADDR_W]);
                if (r_en[p]) begin
                    exp_data[p] = real_reg(a) ? m_regs[a] : '0;
                    exp_busy[p] = real_reg(a) ? m_busy[a] : 1'b0;
                end
            end
            exp_any = 1'b0;
            for (int i = 0; i < int'(DEPTH); i++)
                exp_any = exp_any | m_busy[i];
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int p = 0; p < int'(NUM_RD); p++) begin
                chk($sformatf("model r_data[%0d]", p), 64'(r_data[p*DATA_W +: DATA_W]), 64'(exp_data[p]));
                chk($sformatf("model r_busy[%0d]", p), 64'(r_busy[p]), 64'(exp_busy[p]));
            end
            chk("model busy_any", 64'(busy_any), 64'(exp_any));
        end
    end

    task automatic idle();
        we0   = 1'b0;
        we1   = 1'b0;
        bs_en = 1'b0;
        r_en  = '0;
    endtask

    task automatic rd(input int p, input int a);
        r_en[p] = 1'b1;
        r_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    function automatic logic [DATA_W-1:0] port_data(input int p);
        return r_data[p*DATA_W +: DATA_W];
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checking = 1'b1;
        chk("reset r_data", 64'(r_data), 64'(0));
        chk("reset busy_any", 64'(busy_any), 64'(0));

        // 1: mid-cycle asynchronous reset
        idle(); we0 = 1'b1; w0_addr = 5; w0_data = 32'hDEAD_BEEF; bs_en = 1'b1; bs_addr = 5; rd(0, 5);
        @(negedge clk);
        chk("r5 write", 64'(port_data(0)), 64'hDEAD_BEEF);
        chk("r5 busy set wins", 64'(r_busy[0]), 64'(1));
        chk("r5 busy_any", 64'(busy_any), 64'(1));
        idle(); we0 = 1'b1; w0_addr = 5; w0_data = 32'h1111; rd(0, 5);
        #2 reset = 1'b1;
        #1;
        chk("async reset r_data", 64'(r_data), 64'(0));
        chk("async reset r_busy", 64'(r_busy), 64'(0));
        chk("async reset busy_any", 64'(busy_any), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        idle(); rd(0, 5);
        @(negedge clk);
        chk("r5 after reset", 64'(port_data(0)), 64'(0));

        // 2: write-to-read bypass
        idle(); we0 = 1'b1; w0_addr = 7; w0_data = 32'h1234; rd(0, 7);
        @(negedge clk);
        chk("bypass r7", 64'(port_data(0)), 64'h1234);

        // 3: same-address collision, W1 wins, all ports
        idle(); we0 = 1'b1; w0_addr = 3; w0_data = 32'hAAAA;
        we1 = 1'b1; w1_addr = 3; w1_data = 32'h5555;
        for (int p = 0; p < int'(NUM_RD); p++) rd(p, 3);
        @(negedge clk);
        for (int p = 0; p < int'(NUM_RD); p++)
            chk($sformatf("collision port%0d", p), 64'(port_data(p)), 64'h5555);
        idle(); for (int p = 0; p < int'(NUM_RD); p++) rd(p, 3);
        @(negedge clk);
        chk("collision stored", 64'(port_data(2)), 64'h5555);

        // 4: hardwired zero register
        idle(); we0 = 1'b1; w0_addr = 0; w0_data = 32'hFFFF_FFFF;
        we1 = 1'b1; w1_addr = 0; w1_data = 32'hFFFF_FFFF; bs_en = 1'b1; bs_addr = 0;
        for (int p = 0; p < int'(NUM_RD); p++) rd(p, 0);
        @(negedge clk);
        chk("zero reg data", 64'(r_data), 64'(0));
        chk("zero reg busy", 64'(r_busy), 64'(0));
        chk("zero reg busy_any", 64'(busy_any), 64'(0));

        // 5: scoreboard set / set-beats-clear / clear
        idle(); bs_en = 1'b1; bs_addr = 9; rd(1, 9);
        @(negedge clk);
        chk("sb set r_busy", 64'(r_busy[1]), 64'(1));
        chk("sb set busy_any", 64'(busy_any), 64'(1));
        idle(); bs_en = 1'b1; bs_addr = 9; we1 = 1'b1; w1_addr = 9; w1_data = 32'h99; rd(1, 9);
        @(negedge clk);
        chk("sb set+clear busy", 64'(r_busy[1]), 64'(1));
        chk("sb set+clear data", 64'(port_data(1)), 64'h99);
        idle(); we0 = 1'b1; w0_addr = 9; w0_data = 32'h77; rd(1, 9);
        @(negedge clk);
        chk("sb clear busy", 64'(r_busy[1]), 64'(0));
        chk("sb clear busy_any", 64'(busy_any), 64'(0));
        chk("sb clear data", 64'(port_data(1)), 64'h77);

        // 6: hold when disabled, out-of-range address
        idle(); rd(2, 3);
        @(negedge clk);
        idle(); r_addr[1*ADDR_W +: ADDR_W] = 3; we0 = 1'b1; w0_addr = 9; w0_data = 32'h42;
        @(negedge clk);
        chk("hold data", 64'(port_data(1)), 64'h77);
        chk("hold busy", 64'(r_busy[1]), 64'(0));
        idle(); we0 = 1'b1; w0_addr = ADDR_W'(DEPTH); w0_data = 32'hCAFE; rd(2, int'(DEPTH));
        @(negedge clk);
        chk("out of range DEPTH", 64'(port_data(2)), 64'(0));
        idle(); bs_en = 1'b1; bs_addr = 31; rd(2, 31);
        @(negedge clk);
        chk("out of range 31", 64'(port_data(2)), 64'(0));
        chk("out of range busy_any", 64'(busy_any), 64'(0));

        // Sweep: fill every register through both ports, then read all back on rotating ports
        for (int i = 1; i < int'(DEPTH); i += 2) begin
            idle();
            we0 = 1'b1; w0_addr = ADDR_W'(i); w0_data = 32'hA500_0000 | 32'(i);
            we1 = 1'b1; w1_addr = ADDR_W'(i + 1); w1_data = 32'h5A00_0000 | 32'(i + 1);
            bs_en = 1'b1; bs_addr = ADDR_W'(i);
            rd(0, i); rd(1, i + 1); rd(2, i - 1);
            @(negedge clk);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            idle();
            rd(i % int'(NUM_RD), i);
            if (i % 4 == 0) begin
                we0 = 1'b1; w0_addr = ADDR_W'(i + 1); w0_data = 32'(i * 3);
            end
            @(negedge clk);
        end
        idle(); rd(0, 2);
        @(negedge clk);
        chk("sweep r2", 64'(port_data(0)), 64'h5A00_0002);

        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
